// File: rtl/exception_sequencer.sv
// exception_sequencer
//   Sequences exception entry for a multi-cycle CPU. When the current
//   instruction completes (instr_done=1) and an eligible event is present,
//   the block latches a cause. It then spends one SAVE cycle writing the
//   return address into the error-target register, and one VECTOR cycle
//   forcing the PC to the handler. After that it returns to IDLE.
//
// Ports
//   clk, reset        : rising-edge clock, asynchronous active-low reset
//   irq               : interrupt request (level or pulse), made sticky here
//   undef_inst        : undefined instruction, sampled with instr_done
//   overflow          : ALU signed overflow, sampled with instr_done
//   instr_done        : last cycle of the current instruction
//   kernel_mode       : 1 while executing kernel code (masks irq)
//   er_write, er_i    : error-target register write strobe and index
//   epc_write         : EPC write strobe
//   pc_exc            : forces the PC mux to handler_addr
//   handler_addr      : handler vector, held outside VECTOR
//   cpu_hold          : stalls the CPU control FSM during SAVE/VECTOR
//   cause             : 0 none, 1 irq, 2 undef, 3 overflow
//   exc_count         : saturating count of exceptions taken
//   state_dbg         : current FSM state (0 IDLE, 1 SAVE, 2 VECTOR)
module exception_sequencer #(
  parameter logic [4:0]  ER_REG  = 5'd26,
  parameter logic [31:0] IRQ_VEC = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq,
  input  logic        undef_inst,
  input  logic        overflow,
  input  logic        instr_done,
  input  logic        kernel_mode,
  output logic        er_write,
  output logic [4:0]  er_i,
  output logic        epc_write,
  output logic        pc_exc,
  output logic [31:0] handler_addr,
  output logic        cpu_hold,
  output logic [1:0]  cause,
  output logic [7:0]  exc_count,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAVE   = 2'd1,
    S_VECTOR = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        irq_pending_q, irq_pending_d;
  logic [1:0]  cause_q, cause_d;
  logic [7:0]  exc_count_q, exc_count_d;
  logic [31:0] handler_addr_q, handler_addr_d;
  logic        er_write_q, er_write_d;
  logic        epc_write_q, epc_write_d;
  logic        pc_exc_q, pc_exc_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic [4:0]  er_i_q, er_i_d;

  logic        take;
  logic [1:0]  new_cause;
  logic        irq_seen;

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    take      = 1'b0;
    new_cause = 2'd0;
    // An irq arriving in the same cycle as instr_done is eligible at once.
    irq_seen  = irq_pending_q | irq;

    case (state_q)
      S_IDLE: begin
        if (instr_done) begin
          if (undef_inst) begin
            take      = 1'b1;
            new_cause = 2'd2;
          end else if (overflow) begin
            take      = 1'b1;
            new_cause = 2'd3;
          end else if (irq_seen && !kernel_mode) begin
            take      = 1'b1;
            new_cause = 2'd1;
          end
        end
        if (take) begin
          state_d = S_SAVE;
          cause_d = new_cause;
        end
      end
      S_SAVE:   state_d = S_VECTOR;
      S_VECTOR: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Set has priority over the clear caused by taking the interrupt.
    irq_pending_d = irq | (irq_pending_q & ~(take && (new_cause == 2'd1)));

    exc_count_d = exc_count_q;
    if (take && (exc_count_q != 8'hFF)) exc_count_d = exc_count_q + 8'd1;

    // Outputs are registered, so they are decoded from the next state.
    er_write_d     = (state_d == S_SAVE);
    epc_write_d    = (state_d == S_SAVE);
    er_i_d         = (state_d == S_SAVE) ? ER_REG : 5'd0;
    pc_exc_d       = (state_d == S_VECTOR);
    cpu_hold_d     = (state_d == S_SAVE) || (state_d == S_VECTOR);
    handler_addr_d = handler_addr_q;
    if (state_d == S_VECTOR)
      handler_addr_d = (cause_d == 2'd1) ? IRQ_VEC : EXC_VEC;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      irq_pending_q  <= 1'b0;
      cause_q        <= 2'd0;
      exc_count_q    <= 8'd0;
      handler_addr_q <= 32'd0;
      er_write_q     <= 1'b0;
      epc_write_q    <= 1'b0;
      pc_exc_q       <= 1'b0;
      cpu_hold_q     <= 1'b0;
      er_i_q         <= 5'd0;
    end else begin
      state_q        <= state_d;
      irq_pending_q  <= irq_pending_d;
      cause_q        <= cause_d;
      exc_count_q    <= exc_count_d;
      handler_addr_q <= handler_addr_d;
      er_write_q     <= er_write_d;
      epc_write_q    <= epc_write_d;
      pc_exc_q       <= pc_exc_d;
      cpu_hold_q     <= cpu_hold_d;
      er_i_q         <= er_i_d;
    end
  end

  assign er_write     = er_write_q;
  assign epc_write    = epc_write_q;
  assign er_i         = er_i_q;
  assign pc_exc       = pc_exc_q;
  assign cpu_hold     = cpu_hold_q;
  assign handler_addr = handler_addr_q;
  assign cause        = cause_q;
  assign exc_count    = exc_count_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// tb_exception_sequencer
//   Directed bench for exception_sequencer. Inputs change 1 ns after a
//   rising edge. Outputs are sampled at the same point, so each sample
//   reflects the cycle that the preceding edge started.
//   obs packs {er_write, epc_write, pc_exc, cpu_hold, er_i, cause, exc_count}.
module tb_exception_sequencer;

  localparam logic [31:0] IRQ_VEC = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq, undef_inst, overflow, instr_done, kernel_mode;
  logic        er_write, epc_write, pc_exc, cpu_hold;
  logic [4:0]  er_i;
  logic [31:0] handler_addr;
  logic [1:0]  cause;
  logic [7:0]  exc_count;
  logic [1:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;

  wire [18:0] obs = {er_write, epc_write, pc_exc, cpu_hold, er_i, cause, exc_count};

  exception_sequencer dut (
    .clk(clk), .reset(reset), .irq(irq), .undef_inst(undef_inst),
    .overflow(overflow), .instr_done(instr_done), .kernel_mode(kernel_mode),
    .er_write(er_write), .er_i(er_i), .epc_write(epc_write), .pc_exc(pc_exc),
    .handler_addr(handler_addr), .cpu_hold(cpu_hold), .cause(cause),
    .exc_count(exc_count), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic i, input logic u, input logic o,
                       input logic d, input logic k);
    irq = i; undef_inst = u; overflow = o; instr_done = d; kernel_mode = k;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    step(); step();
    n_vec++;
    if (obs !== 19'd0) begin
      n_err++; $display("FAIL reset_outputs obs=%h exp=%h", obs, 19'd0);
    end
    n_vec++;
    if (handler_addr !== 32'd0 || state_dbg !== 2'd0) begin
      n_err++; $display("FAIL reset_handler_state handler=%h state=%0d exp 0/0", handler_addr, state_dbg);
    end
    reset = 1'b1;
  endtask

  // irq taken on the first edge after reset release
  task automatic test_irq();
    drive(1, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== {1'b1, 1'b1, 1'b0, 1'b1, 5'd26, 2'd1, 8'd1}) begin
      n_err++; $display("FAIL irq_save obs=%h exp=%h", obs, {1'b1, 1'b1, 1'b0, 1'b1, 5'd26, 2'd1, 8'd1});
    end
    step();
    n_vec++;
    if (obs !== {1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 2'd1, 8'd1} || handler_addr !== IRQ_VEC) begin
      n_err++; $display("FAIL irq_vector obs=%h handler=%h exp obs=%h handler=%h", obs, handler_addr,
                        {1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 2'd1, 8'd1}, IRQ_VEC);
    end
    step();
    n_vec++;
    if (obs !== {4'b0000, 5'd0, 2'd1, 8'd1} || handler_addr !== IRQ_VEC || state_dbg !== 2'd0) begin
      n_err++; $display("FAIL irq_idle obs=%h handler=%h state=%0d exp obs=%h handler=%h state=0",
                        obs, handler_addr, state_dbg, {4'b0000, 5'd0, 2'd1, 8'd1}, IRQ_VEC);
    end
  endtask

  // undef beats overflow beats irq; irq stays pending for later
  task automatic test_priority();
    drive(1, 1, 1, 1, 0);
    step();
    drive(0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== {1'b1, 1'b1, 1'b0, 1'b1, 5'd26, 2'd2, 8'd2}) begin
      n_err++; $display("FAIL prio_save obs=%h exp=%h", obs, {1'b1, 1'b1, 1'b0, 1'b1, 5'd26, 2'd2, 8'd2});
    end
    step();
    n_vec++;
    if (pc_exc !== 1'b1 || handler_addr !== EXC_VEC || cause !== 2'd2) begin
      n_err++; $display("FAIL prio_vector pc_exc=%b handler=%h cause=%0d exp 1/%h/2", pc_exc, handler_addr, cause, EXC_VEC);
    end
    step();
    drive(0, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== {1'b1, 1'b1, 1'b0, 1'b1, 5'd26, 2'd1, 8'd3}) begin
      n_err++; $display("FAIL prio_pending_irq obs=%h exp=%h", obs, {1'b1, 1'b1, 1'b0, 1'b1, 5'd26, 2'd1, 8'd3});
    end
    step();
    n_vec++;
    if (handler_addr !== IRQ_VEC || pc_exc !== 1'b1) begin
      n_err++; $display("FAIL prio_irq_vector handler=%h pc_exc=%b exp %h/1", handler_addr, pc_exc, IRQ_VEC);
    end
    step();
  endtask

  // irq masked in kernel mode, taken once user mode completes an instruction
  task automatic test_kernel();
    int hits;
    drive(1, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 1, 1);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (er_write !== 1'b0 || cpu_hold !== 1'b0) hits++;
    end
    n_vec++;
    if (hits !== 0) begin
      n_err++; $display("FAIL kernel_masked active_cycles=%0d exp 0", hits);
    end
    drive(0, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== {1'b1, 1'b1, 1'b0, 1'b1, 5'd26, 2'd1, 8'd4}) begin
      n_err++; $display("FAIL kernel_release obs=%h exp=%h", obs, {1'b1, 1'b1, 1'b0, 1'b1, 5'd26, 2'd1, 8'd4});
    end
    step(); step();
  endtask

  // overflow without instr_done never starts a sequence
  task automatic test_no_done();
    int hits;
    drive(0, 0, 1, 0, 0);
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (cpu_hold !== 1'b0 || er_write !== 1'b0) hits++;
    end
    drive(0, 0, 0, 0, 0);
    n_vec++;
    if (hits !== 0 || exc_count !== 8'd4) begin
      n_err++; $display("FAIL no_done active_cycles=%0d count=%0d exp 0/4", hits, exc_count);
    end
  endtask

  // reset during SAVE clears everything at once and aborts the sequence
  task automatic test_reset_mid();
    int hits;
    drive(0, 0, 1, 1, 0);
    step();
    drive(0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== {1'b1, 1'b1, 1'b0, 1'b1, 5'd26, 2'd3, 8'd5}) begin
      n_err++; $display("FAIL resetmid_save obs=%h exp=%h", obs, {1'b1, 1'b1, 1'b0, 1'b1, 5'd26, 2'd3, 8'd5});
    end
    #1 reset = 1'b0;
    #1;
    n_vec++;
    if (obs !== 19'd0 || handler_addr !== 32'd0) begin
      n_err++; $display("FAIL resetmid_async obs=%h handler=%h exp 0/0", obs, handler_addr);
    end
    step(); step();
    reset = 1'b1;
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (pc_exc !== 1'b0 || er_write !== 1'b0) hits++;
    end
    n_vec++;
    if (hits !== 0 || obs !== 19'd0) begin
      n_err++; $display("FAIL resetmid_after strobes=%0d obs=%h exp 0/0", hits, obs);
    end
  endtask

  // irq arriving on the cycle a pending irq is taken keeps it pending
  task automatic test_set_wins();
    drive(1, 0, 0, 0, 0);
    step();
    drive(1, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== {1'b1, 1'b1, 1'b0, 1'b1, 5'd26, 2'd1, 8'd1}) begin
      n_err++; $display("FAIL setwins_first obs=%h exp=%h", obs, {1'b1, 1'b1, 1'b0, 1'b1, 5'd26, 2'd1, 8'd1});
    end
    step(); step();
    drive(0, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== {1'b1, 1'b1, 1'b0, 1'b1, 5'd26, 2'd1, 8'd2}) begin
      n_err++; $display("FAIL setwins_second obs=%h exp=%h", obs, {1'b1, 1'b1, 1'b0, 1'b1, 5'd26, 2'd1, 8'd2});
    end
    step(); step();
  endtask

  // 300 back-to-back overflow exceptions: 3-cycle cadence, count saturates
  task automatic test_back_to_back();
    logic [7:0] exp_cnt;
    exp_cnt = 8'd2;
    drive(0, 0, 1, 1, 0);
    for (int i = 0; i < 300; i++) begin
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      step();
      n_vec++;
      if (obs !== {1'b1, 1'b1, 1'b0, 1'b1, 5'd26, 2'd3, exp_cnt}) begin
        n_err++; $display("FAIL b2b_save[%0d] obs=%h exp=%h", i, obs, {1'b1, 1'b1, 1'b0, 1'b1, 5'd26, 2'd3, exp_cnt});
      end
      step();
      n_vec++;
      if (obs !== {1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 2'd3, exp_cnt} || handler_addr !== EXC_VEC) begin
        n_err++; $display("FAIL b2b_vector[%0d] obs=%h handler=%h exp=%h", i, obs, handler_addr,
                          {1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 2'd3, exp_cnt});
      end
      step();
      n_vec++;
      if (obs !== {4'b0000, 5'd0, 2'd3, exp_cnt}) begin
        n_err++; $display("FAIL b2b_idle[%0d] obs=%h exp=%h", i, obs, {4'b0000, 5'd0, 2'd3, exp_cnt});
      end
    end
    drive(0, 0, 0, 0, 0);
    step();
    n_vec++;
    if (exc_count !== 8'hFF) begin
      n_err++; $display("FAIL b2b_saturated count=%h exp=ff", exc_count);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_irq();
    test_priority();
    test_kernel();
    test_no_done();
    test_reset_mid();
    test_set_wins();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
